// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-port and status signals around the shared memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              stall_mem_ready;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              bus_err;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_rdata, dm_rdata, stall_mem_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_rdata, dm_rdata, stall_mem_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises the data (first) and fetch requests of one pipeline bundle onto a single-port
// memory, freezing the pipeline until both are served; a wait watchdog aborts hung accesses.
module mem_port_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;

   state_t            state_q, state_d;
   logic              if_done_q, if_done_d;
   logic              dm_done_q, dm_done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              bus_err_q, bus_err_d;
   logic              if_pend, dm_pend, expired, txn_end;

   function automatic logic wd_expired(input logic [CNT_W-1:0] cnt, input logic ready);
      return !ready && (cnt == CNT_W'(WAIT_LIMIT - 1));
   endfunction

   // An aborted read returns zero so the core never consumes stale bus data.
   function automatic logic [DATA_W-1:0] rd_capture(input logic ready,
                                                    input logic [DATA_W-1:0] rdata);
      return ready ? rdata : '0;
   endfunction

   assign if_pend = bus.if_req & ~if_done_q;
   assign dm_pend = bus.dm_req & ~dm_done_q;
   assign expired = wd_expired(cnt_q, bus.mem_ready);
   assign txn_end = bus.mem_ready | expired;

   always_comb begin
      state_d     = state_q;
      if_done_d   = if_done_q;
      dm_done_d   = dm_done_q;
      cnt_d       = cnt_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      bus_err_d   = bus_err_q;

      case (state_q)
         IDLE: begin
            if (dm_pend) begin
               state_d     = DATA;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.dm_we;
               mem_addr_d  = bus.dm_addr;
               mem_wdata_d = bus.dm_wdata;
               cnt_d       = '0;
            end else if (if_pend) begin
               state_d     = INSTR;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.if_addr;
               mem_wdata_d = '0;
               cnt_d       = '0;
            end else begin
               // Nothing outstanding: the bundle retires and the next one starts clean.
               if_done_d = 1'b0;
               dm_done_d = 1'b0;
            end
         end

         DATA: begin
            if (txn_end) begin
               dm_done_d = 1'b1;
               if (!mem_we_q) dm_rdata_d = rd_capture(bus.mem_ready, bus.mem_rdata);
               if (expired) bus_err_d = 1'b1;
               cnt_d = '0;
               if (if_pend) begin
                  state_d     = INSTR;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = bus.if_addr;
                  mem_wdata_d = '0;
               end else begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         INSTR: begin
            if (txn_end) begin
               if_done_d  = 1'b1;
               if_rdata_d = rd_capture(bus.mem_ready, bus.mem_rdata);
               if (expired) bus_err_d = 1'b1;
               cnt_d     = '0;
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         if_done_q   <= 1'b0;
         dm_done_q   <= 1'b0;
         cnt_q       <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         if_done_q   <= if_done_d;
         dm_done_q   <= dm_done_d;
         cnt_q       <= cnt_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus.stall_mem_ready = if_pend | dm_pend;
   assign bus.if_rdata        = if_rdata_q;
   assign bus.dm_rdata        = dm_rdata_q;
   assign bus.mem_req         = mem_req_q;
   assign bus.mem_we          = mem_we_q;
   assign bus.mem_addr        = mem_addr_q;
   assign bus.mem_wdata       = mem_wdata_q;
   assign bus.bus_err         = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed bundles push expected memory transactions
// and per-bundle results; independent monitors pop and compare as the DUT produces them.
module tb_mem_port_arbiter;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_LIMIT(15), .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } txn_t;

   typedef struct {
      int          stall;
      logic [15:0] ird;
      logic [15:0] drd;
      logic        berr;
   } rsp_t;

   txn_t exp_txn[$];
   rsp_t exp_rsp[$];
   txn_t cur;

   int n_chk  = 0;
   int n_fail = 0;

   // Memory model: ready after mem_lat wait cycles (negative = never), fixed read contents.
   int   mem_lat   = 0;
   logic force_rdy = 1'b0;
   int   wcnt      = 0;

   function automatic logic [15:0] mem_lookup(input logic [15:0] a);
      case (a)
         16'h0200: return 16'hBEEF;
         16'h0010: return 16'h9A41;
         default:  return a ^ 16'h5A5A;
      endcase
   endfunction

   assign bus.mem_ready = force_rdy | (bus.mem_req && (mem_lat >= 0) && (wcnt == mem_lat));
   assign bus.mem_rdata = mem_lookup(bus.mem_addr);

   always @(posedge clk) begin
      if (!bus.mem_req || bus.mem_ready) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_txn(input logic we, input logic [15:0] addr, input logic [15:0] wd);
      txn_t t;
      t.we = we; t.addr = addr; t.wdata = wd;
      exp_txn.push_back(t);
   endtask

   task automatic push_rsp(input int st, input logic [15:0] ird, input logic [15:0] drd,
                           input logic berr);
      rsp_t r;
      r.stall = st; r.ird = ird; r.drd = drd; r.berr = berr;
      exp_rsp.push_back(r);
   endtask

   task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                        input logic [15:0] da, input logic [15:0] dwd);
      bus.if_req   = ir;
      bus.if_addr  = ia;
      bus.dm_req   = dr;
      bus.dm_we    = dw;
      bus.dm_addr  = da;
      bus.dm_wdata = dwd;
   endtask

   // Returns at the first falling-edge sample with the stall released; counts mem_req cycles.
   task automatic wait_release(input string name, output int req_cyc);
      int n;
      n = 0;
      req_cyc = 0;
      do begin
         @(negedge clk);
         if (bus.mem_req) req_cyc++;
         n++;
      end while (bus.stall_mem_ready && n < 200);
      if (bus.stall_mem_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_release: stall still 1 after %0d cycles, required 0", name, n);
      end
   endtask

   // Transaction monitor: first cycle of each access pops an expectation, later cycles check hold.
   logic prev_req = 1'b0;
   logic prev_rdy = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_req = 1'b0;
         prev_rdy = 1'b0;
      end else begin
         if (bus.mem_req) begin
            if (!prev_req || prev_rdy) begin
               if (exp_txn.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL txn_unexpected: addr 0x%0h issued, required no access",
                           bus.mem_addr);
                  cur.we = bus.mem_we; cur.addr = bus.mem_addr; cur.wdata = bus.mem_wdata;
               end else begin
                  cur = exp_txn.pop_front();
                  chk("txn_we", bus.mem_we, cur.we);
                  chk("txn_addr", bus.mem_addr, cur.addr);
                  chk("txn_wdata", bus.mem_wdata, cur.wdata);
               end
            end else begin
               chk("hold_we", bus.mem_we, cur.we);
               chk("hold_addr", bus.mem_addr, cur.addr);
               chk("hold_wdata", bus.mem_wdata, cur.wdata);
            end
         end
         prev_req = bus.mem_req;
         prev_rdy = bus.mem_ready;
      end
   end

   // Bundle monitor: when the stall releases, compare its length and the delivered results.
   int scnt = 0;
   always @(negedge clk) begin
      rsp_t r;
      if (rst) begin
         scnt = 0;
      end else if (bus.stall_mem_ready) begin
         scnt++;
      end else if (scnt > 0) begin
         if (exp_rsp.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_unexpected: stall of %0d cycles, required none", scnt);
         end else begin
            r = exp_rsp.pop_front();
            chk("stall_len", scnt, r.stall);
            chk("if_rdata", bus.if_rdata, r.ird);
            chk("dm_rdata", bus.dm_rdata, r.drd);
            chk("bus_err", bus.bus_err, r.berr);
         end
         scnt = 0;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1, "time limit reached");
   end

   initial begin
      int rc;
      rst = 1'b1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("init_mem_req", bus.mem_req, 0);
      chk("init_stall", bus.stall_mem_ready, 0);
      chk("init_bus_err", bus.bus_err, 0);
      chk("init_if_rdata", bus.if_rdata, 0);
      chk("init_dm_rdata", bus.dm_rdata, 0);
      @(negedge clk);
      #2 rst = 1'b0;

      // Load plus fetch, zero-wait memory: data first, then fetch, back to back.
      @(posedge clk); #1;
      mem_lat = 0;
      push_txn(1'b0, 16'h0200, 16'h0000);
      push_txn(1'b0, 16'h0010, 16'h0000);
      push_rsp(3, 16'h9A41, 16'hBEEF, 1'b0);
      drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 16'h0000);
      wait_release("both", rc);
      chk("both_req_cycles", rc, 2);
      @(posedge clk); #1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk("retired_stall", bus.stall_mem_ready, 0);
      chk("retired_mem_req", bus.mem_req, 0);

      // Store, memory ready on the third request cycle; dm_rdata must not move.
      @(posedge clk); #1;
      mem_lat = 2;
      push_txn(1'b1, 16'h0033, 16'h1234);
      push_rsp(4, 16'h9A41, 16'hBEEF, 1'b0);
      drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0033, 16'h1234);
      wait_release("store", rc);
      chk("store_req_cycles", rc, 3);
      @(posedge clk); #1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Two consecutive fetch bundles with the request held high across the boundary.
      @(posedge clk); #1;
      mem_lat = 1;
      push_txn(1'b0, 16'h0100, 16'h0000);
      push_rsp(3, 16'h5B5A, 16'hBEEF, 1'b0);
      drive(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0, 16'h0);
      wait_release("fetch_a", rc);
      chk("fetch_a_req_cycles", rc, 2);
      chk("gap_mem_req", bus.mem_req, 0);
      push_txn(1'b0, 16'h0104, 16'h0000);
      push_rsp(3, 16'h5B5E, 16'hBEEF, 1'b0);
      @(posedge clk); #1;
      bus.if_addr = 16'h0104;
      wait_release("fetch_b", rc);
      chk("fetch_b_req_cycles", rc, 2);
      @(posedge clk); #1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Hung memory on a fetch: watchdog aborts after 15 request cycles.
      @(posedge clk); #1;
      mem_lat = -1;
      push_txn(1'b0, 16'h0400, 16'h0000);
      push_rsp(16, 16'h0000, 16'hBEEF, 1'b1);
      drive(1'b1, 16'h0400, 1'b0, 1'b0, 16'h0, 16'h0);
      wait_release("wdog", rc);
      chk("wdog_req_cycles", rc, 15);
      @(posedge clk); #1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

      // A good fetch afterwards completes normally; the error stays sticky.
      @(posedge clk); #1;
      mem_lat = 0;
      push_txn(1'b0, 16'h0010, 16'h0000);
      push_rsp(2, 16'h9A41, 16'hBEEF, 1'b1);
      drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
      wait_release("after_wdog", rc);
      chk("after_wdog_req_cycles", rc, 1);
      @(posedge clk); #1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Spurious mem_ready with nothing requested must be ignored.
      @(posedge clk); #1;
      force_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("spur_stall", bus.stall_mem_ready, 0);
         chk("spur_mem_req", bus.mem_req, 0);
         chk("spur_if_rdata", bus.if_rdata, 16'h9A41);
         chk("spur_dm_rdata", bus.dm_rdata, 16'hBEEF);
      end
      @(posedge clk); #1;
      force_rdy = 1'b0;

      // Reset in the middle of a data access with the wait counter at 5.
      mem_lat = -1;
      push_txn(1'b0, 16'h0200, 16'h0000);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0000);
      rc = 0;
      do begin
         @(negedge clk);
         rc++;
      end while (!bus.mem_req && rc < 20);
      chk("mid_reset_issue", bus.mem_req, 1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      rst = 1'b1;
      #1;
      chk("arst_mem_req", bus.mem_req, 0);
      chk("arst_stall", bus.stall_mem_ready, 0);
      chk("arst_bus_err", bus.bus_err, 0);
      chk("arst_if_rdata", bus.if_rdata, 0);
      chk("arst_dm_rdata", bus.dm_rdata, 0);
      chk("arst_mem_addr", bus.mem_addr, 0);
      chk("arst_mem_we", bus.mem_we, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      mem_lat = 0;
      @(negedge clk);
      chk("post_rst_stall", bus.stall_mem_ready, 0);
      chk("post_rst_mem_req", bus.mem_req, 0);

      // Full bundle again from IDLE after reset.
      @(posedge clk); #1;
      push_txn(1'b0, 16'h0200, 16'h0000);
      push_txn(1'b0, 16'h0010, 16'h0000);
      push_rsp(3, 16'h9A41, 16'hBEEF, 1'b0);
      drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 16'h0000);
      wait_release("post_rst_both", rc);
      chk("post_rst_req_cycles", rc, 2);
      @(posedge clk); #1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("txn_queue_left", exp_txn.size(), 0);
      chk("rsp_queue_left", exp_rsp.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (read-only) and the data-memory requester (LD/ST from the MEM stage).
- Serialises both requests for the current pipeline bundle: data first, then fetch.
- Holds the pipeline frozen via stall_mem_ready until every active request has completed.
- A wait-limit watchdog prevents a hung memory from locking up the core.

Parameters:
- ADDR_W, 16, address width of both requesters and the memory port
- DATA_W, 16, data width
- WAIT_LIMIT, 15, maximum cycles a memory transaction may wait for mem_ready before it is aborted (1..2^CNT_W-1)
- CNT_W, 4, width of the wait counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request for the current bundle
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, registered
- dm_req  in  1  data request for the current bundle
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load result, registered
- stall_mem_ready  out  1  pipeline freeze
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  single-cycle completion; may assert in any cycle mem_req is high, including the first
- bus_err  out  1  sticky watchdog error

Behaviour:
- Reset (async): state IDLE. if_done, dm_done, wait counter, if_rdata, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata and bus_err all go to 0 immediately. Any in-flight transaction is abandoned.
- States: IDLE, DATA, INSTR.
- stall_mem_ready is combinational: (if_req & !if_done) | (dm_req & !dm_done).
- Requesters hold req/addr/we/wdata stable while stall_mem_ready=1. A request dropped before it is issued is simply not served.
- IDLE:
  - If dm_req & !dm_done, go to DATA.
  - Else if if_req & !if_done, go to INSTR.
  - Else, when stall_mem_ready=0, clear if_done and dm_done at this edge (bundle retired).
  - Data always has priority over fetch within a bundle.
- On entry to DATA, registered at the transition edge: mem_req=1, mem_we=dm_we, mem_addr=dm_addr, mem_wdata=dm_wdata.
- On entry to INSTR: mem_req=1, mem_we=0, mem_addr=if_addr, mem_wdata=0.
- Outputs are held constant while in DATA or INSTR. The wait counter resets to 0 on entry and increments each cycle mem_ready=0.
- DATA with mem_ready=1:
  - dm_rdata <= mem_rdata when dm_we=0; dm_rdata is unchanged on a store.
  - dm_done <= 1.
  - Next state is INSTR (with mem_* reloaded for fetch) if if_req & !if_done, else IDLE with mem_req=0.
  - Back-to-back issue: no idle cycle between DATA and INSTR.
- INSTR with mem_ready=1: if_rdata <= mem_rdata, if_done <= 1, go to IDLE, mem_req=0.
- Watchdog: in DATA/INSTR with mem_ready=0 and counter == WAIT_LIMIT-1:
  - Abort the transaction and set bus_err=1 (sticky until reset).
  - Mark the requester done. Its rdata is forced to 0 (store abort leaves dm_rdata unchanged).
  - Continue as on normal completion.
  - The pipeline therefore never stalls longer than 2*WAIT_LIMIT+1 cycles per bundle.
- Latency, zero-wait memory:
  - Both requests: stall high 3 cycles (IDLE, DATA, INSTR).
  - One request: stall high 2 cycles.
  - No request: stall stays 0.
- mem_ready asserted while mem_req=0 is ignored.

Test Plan:
- Reset mid-DATA (mem_req=1, counter=5): assert rst -> mem_req, stall_mem_ready (with reqs low), bus_err, rdata outputs all 0 asynchronously; after release state is IDLE.
- if_req=1 if_addr=0x0010, dm_req=1 dm_we=0 dm_addr=0x0200, memory ready same cycle with rdata 0xBEEF(data)/0x9A41(fetch):
  - mem_addr sequence is 0x0200 then 0x0010.
  - dm_rdata=0xBEEF, if_rdata=0x9A41.
  - stall_mem_ready high exactly 3 cycles.
  - Done flags clear on the following edge.
- Store dm_we=1 dm_addr=0x0033 dm_wdata=0x1234, no if_req, mem_ready after 3 cycles:
  - mem_we=1, mem_wdata=0x1234 held for 3 cycles.
  - dm_rdata unchanged; stall drops the cycle after completion.
- Fetch only, mem_ready never asserted, WAIT_LIMIT=15:
  - mem_req drops after 15 cycles, bus_err=1, if_rdata=0x0000, stall releases.
  - A subsequent good fetch completes normally while bus_err stays 1.
- Two consecutive bundles, fetch-only, memory ready on the 2nd cycle of each request: the second fetch issues only after stall_mem_ready has been 0 for one cycle; if_rdata updates per bundle.
- Spurious mem_ready=1 in IDLE with no requests: no state change, rdata outputs unchanged, stall_mem_ready=0.
